// File: rtl/config_chain_loader.sv
// Configuration-chain loader: takes word-wide configuration data over valid/ready
// and shifts it LSB-first into a serial DFF chain for exactly CHAIN_LEN cycles.
module config_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [WORD_W-1:0] CFG_DATA,
  input  logic              CFG_VALID,
  output logic              CFG_READY,
  output logic              CCFF_HEAD,
  output logic              PROG_EN,
  output logic              BUSY,
  output logic              DONE
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WB_W-1:0]  LAST_WBIT = WB_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] sreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WB_W-1:0]   word_bit;

  // NOTE: all state here uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      sreg     <= '0;
      bit_cnt  <= '0;
      word_bit <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            state    <= S_LOAD;
            bit_cnt  <= '0;
            word_bit <= '0;
          end
        end

        S_LOAD: begin
          if (CFG_VALID) begin
            sreg     <= CFG_DATA;
            word_bit <= '0;
            state    <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          sreg     <= sreg >> 1;
          bit_cnt  <= bit_cnt + CNT_W'(1);
          word_bit <= word_bit + WB_W'(1);
          // Chain end wins over word end, so a partial final word is simply dropped.
          if (bit_cnt == LAST_BIT) begin
            state <= S_DONE;
          end else if (word_bit == LAST_WBIT) begin
            state <= S_LOAD;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: outputs are pure decodes of registered state with every path assigned,
  // so there is no input-to-output path and no latch can be inferred.
  assign CFG_READY = (state == S_LOAD);
  assign PROG_EN   = (state == S_SHIFT);
  assign CCFF_HEAD = (state == S_SHIFT) ? sreg[0] : 1'b0;
  assign BUSY      = (state == S_LOAD) || (state == S_SHIFT);
  assign DONE      = (state == S_DONE);

endmodule

// File: tb/tb_config_chain_loader.sv
// Self-checking bench for config_chain_loader: cycle table, directed corner cases
// and randomized runs against a bit-stream chain model.
module tb_config_chain_loader;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RESET;

  // Main instance: CHAIN_LEN=20, WORD_W=8
  logic       a_start, a_valid, a_ready, a_head, a_prog, a_busy, a_done;
  logic [7:0] a_data;
  // Exact-multiple instance: CHAIN_LEN=16, WORD_W=8
  logic       b_start, b_valid, b_ready, b_head, b_prog, b_busy, b_done;
  logic [7:0] b_data;
  // Single-bit instance: CHAIN_LEN=4, WORD_W=1
  logic       c_start, c_valid, c_ready, c_head, c_prog, c_busy, c_done;
  logic [0:0] c_data;

  config_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut_a (
    .CLK(CLK), .RESET(RESET), .START(a_start), .CFG_DATA(a_data), .CFG_VALID(a_valid),
    .CFG_READY(a_ready), .CCFF_HEAD(a_head), .PROG_EN(a_prog), .BUSY(a_busy), .DONE(a_done)
  );

  config_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut_b (
    .CLK(CLK), .RESET(RESET), .START(b_start), .CFG_DATA(b_data), .CFG_VALID(b_valid),
    .CFG_READY(b_ready), .CCFF_HEAD(b_head), .PROG_EN(b_prog), .BUSY(b_busy), .DONE(b_done)
  );

  config_chain_loader #(.CHAIN_LEN(4), .WORD_W(1)) dut_c (
    .CLK(CLK), .RESET(RESET), .START(c_start), .CFG_DATA(c_data), .CFG_VALID(c_valid),
    .CFG_READY(c_ready), .CCFF_HEAD(c_head), .PROG_EN(c_prog), .BUSY(c_busy), .DONE(c_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Chain model for dut_a: a 20-cell chain that shifts toward the tail (bit 0)
  // on every PROG_EN edge, plus running counts of shift cycles and handshakes.
  int          a_prog_cnt = 0;
  int          a_hs_cnt   = 0;
  logic [19:0] a_img      = '0;

  always @(negedge CLK) begin
    if (a_prog === 1'b1) begin
      a_prog_cnt++;
      a_img = {a_head, a_img[19:1]};
    end
    if (a_ready === 1'b1 && a_valid === 1'b1) a_hs_cnt++;
  end

  // Expected chain image: stream bit k is bit (k % 8) of word (k / 8); the first
  // bit shifted ends at the tail (index 0), the 20th at the head.
  function automatic logic [19:0] ref_image(input logic [2:0][7:0] w);
    logic [19:0] img;
    for (int k = 0; k < 20; k++) img[k] = w[k / 8][k % 8];
    return img;
  endfunction

  typedef struct {
    logic       start;
    logic       valid;
    logic [7:0] data;
    logic [4:0] exp;    // {ready, prog, head, busy, done}
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic start, input logic valid, input logic [7:0] data,
                              input logic ready, input logic prog, input logic head,
                              input logic busy, input logic done);
    vec_t v;
    v.start = start;
    v.valid = valid;
    v.data  = data;
    v.exp   = {ready, prog, head, busy, done};
    tbl.push_back(v);
  endfunction

  // One full programming run on dut_a; gaps[i] = idle VALID cycles before word i.
  task automatic run_a(input logic [2:0][7:0] w, input logic [2:0][3:0] gaps,
                       input bit mid_start, input bit started, input string tag);
    int p0, h0;
    bit ok;
    p0 = a_prog_cnt;
    h0 = a_hs_cnt;
    if (!started) begin
      a_start = 1'b1;
      @(posedge CLK); #1;
      a_start = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
        if (a_ready) begin
          ok = 1'b1;
          break;
        end
        @(posedge CLK); #1;
      end
      check({tag, " ready_wait"}, 32'(ok), 32'd1);
      for (int g = 0; g < int'(gaps[i]); g++) begin
        a_valid = 1'b0;
        check({tag, " stall_ready_prog"}, {30'd0, a_ready, a_prog}, 32'h2);
        @(posedge CLK); #1;
      end
      a_valid = 1'b1;
      a_data  = w[i];
      @(posedge CLK); #1;
      a_valid = 1'b0;
      a_data  = 8'($urandom);
      if (mid_start && i == 0) begin
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        a_start = 1'b1;
        check({tag, " third_shift_prog"}, 32'(a_prog), 32'd1);
        @(posedge CLK); #1;
        a_start = 1'b0;
      end
    end
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (a_done) begin
        ok = 1'b1;
        break;
      end
      @(posedge CLK); #1;
    end
    check({tag, " done_reached"}, 32'(ok), 32'd1);
    check({tag, " busy_after_done"}, 32'(a_busy), 32'd0);
    check({tag, " prog_cycles"}, 32'(a_prog_cnt - p0), 32'd20);
    check({tag, " handshakes"}, 32'(a_hs_cnt - h0), 32'd3);
    check({tag, " chain_image"}, 32'(a_img), 32'(ref_image(w)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0][7:0] w;
    logic [2:0][3:0] gaps;
    int p0;
    bit ok;

    RESET   = 1'b1;
    a_start = 1'b0; a_valid = 1'b0; a_data = '0;
    b_start = 1'b0; b_valid = 1'b0; b_data = '0;
    c_start = 1'b0; c_valid = 1'b0; c_data = '0;
    #3;
    check("reset_outputs", {17'd0, a_ready, a_head, a_prog, a_busy, a_done,
                            b_ready, b_head, b_prog, b_busy, b_done,
                            c_ready, c_head, c_prog, c_busy, c_done}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Cycle-by-cycle table: 0xA5, 0x3C, 0xF9 with VALID held high.
    w = {8'hF9, 8'h3C, 8'hA5};
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      add(1'b0, 1'b1, w[i], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int b = 0; b < ((i < 2) ? 8 : 4); b++)
        add(1'b0, 1'b1, (i < 2) ? w[i + 1] : 8'h00, 1'b0, 1'b1, w[i][b], 1'b1, 1'b0);
    end
    add(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    p0 = a_prog_cnt;
    for (int i = 0; i < tbl.size(); i++) begin
      check($sformatf("vec%0d {ready,prog,head,busy,done}", i),
            {27'd0, a_ready, a_prog, a_head, a_busy, a_done}, {27'd0, tbl[i].exp});
      a_start = tbl[i].start;
      a_valid = tbl[i].valid;
      a_data  = tbl[i].data;
      @(posedge CLK); #1;
    end
    a_valid = 1'b0;
    check("table prog_cycles", 32'(a_prog_cnt - p0), 32'd20);
    check("table handshakes", 32'(a_hs_cnt), 32'd3);
    check("table chain_image", 32'(a_img), 32'(ref_image(w)));

    // VALID withheld for 5 cycles before the third word; same image expected.
    gaps = {4'd5, 4'd0, 4'd0};
    run_a(w, gaps, 1'b0, 1'b0, "gap");

    // START mid-SHIFT is ignored; START in DONE restarts immediately.
    gaps = '0;
    w = {8'h17, 8'hE2, 8'h6B};
    run_a(w, gaps, 1'b1, 1'b0, "midstart");
    a_start = 1'b1;
    check("restart done_before_edge", 32'(a_done), 32'd1);
    @(posedge CLK); #1;
    a_start = 1'b0;
    check("restart {ready,done}", {30'd0, a_ready, a_done}, 32'h2);
    w = {8'h0C, 8'h99, 8'h42};
    run_a(w, gaps, 1'b0, 1'b1, "rerun");

    // Asynchronous reset in the 11th SHIFT cycle (bit_cnt=10).
    a_start = 1'b1;
    @(posedge CLK); #1;
    a_start = 1'b0;
    a_valid = 1'b1;
    a_data  = 8'hA5;
    p0 = a_prog_cnt;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (a_prog_cnt - p0 == 10 && a_prog) begin
        ok = 1'b1;
        break;
      end
      @(posedge CLK); #1;
    end
    check("abort reached_bit10", 32'(ok), 32'd1);
    #2 RESET = 1'b1;
    #1;
    check("abort outputs_async", {27'd0, a_ready, a_head, a_prog, a_busy, a_done}, 32'd0);
    RESET   = 1'b0;
    a_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      check("abort idle {ready,prog,busy}", {29'd0, a_ready, a_prog, a_busy}, 32'd0);
    end
    w = {8'h3D, 8'h80, 8'hFF};
    run_a(w, gaps, 1'b0, 1'b0, "postreset");

    // Randomized runs against the chain model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 3; i++) begin
        w[i]    = 8'($urandom);
        gaps[i] = 4'($urandom_range(0, 4));
      end
      run_a(w, gaps, 1'b0, 1'b0, $sformatf("rand%0d", r));
    end

    // CHAIN_LEN=16, WORD_W=8: two words, DONE straight after the 16th shift.
    begin
      logic [1:0][7:0] wb;
      logic [15:0]     img_b;
      int              idx, ready_cyc, prog_cyc;
      bit              last_prog, done_seen;
      wb = {8'hC3, 8'h5A};
      idx = 0; ready_cyc = 0; prog_cyc = 0;
      last_prog = 1'b0; done_seen = 1'b0; img_b = '0;
      b_start = 1'b1;
      @(posedge CLK); #1;
      b_start = 1'b0;
      b_valid = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
        b_data = (idx < 2) ? wb[idx] : 8'hEE;
        if (b_done && !done_seen) begin
          done_seen = 1'b1;
          check("b shifts_at_done", 32'(prog_cyc), 32'd16);
          check("b prog_just_before_done", 32'(last_prog), 32'd1);
        end
        if (b_ready) begin
          ready_cyc++;
          idx++;
        end
        if (b_prog) begin
          prog_cyc++;
          img_b = {b_head, img_b[15:1]};
        end
        last_prog = b_prog;
        @(posedge CLK); #1;
      end
      b_valid = 1'b0;
      check("b done_seen", 32'(done_seen), 32'd1);
      check("b load_entries", 32'(ready_cyc), 32'd2);
      check("b prog_cycles", 32'(prog_cyc), 32'd16);
      check("b chain_image", 32'(img_b), 32'hC35A);
    end

    // CHAIN_LEN=4, WORD_W=1: LOAD and SHIFT alternate, one bit per handshake.
    begin
      logic [3:0] bits, stream;
      int         idx, ready_cyc, prog_cyc, busy_cyc, back_to_back;
      bit         last_prog, last_ready;
      bits = 4'b1101;   // shifted order 1,0,1,1
      idx = 0; ready_cyc = 0; prog_cyc = 0; busy_cyc = 0; back_to_back = 0;
      last_prog = 1'b0; last_ready = 1'b0; stream = '0;
      c_start = 1'b1;
      @(posedge CLK); #1;
      c_start = 1'b0;
      c_valid = 1'b1;
      for (int cyc = 0; cyc < 20 && !c_done; cyc++) begin
        c_data[0] = (idx < 4) ? bits[idx] : 1'b0;
        if (c_busy) busy_cyc++;
        if ((c_prog && last_prog) || (c_ready && last_ready)) back_to_back++;
        if (c_ready) begin
          ready_cyc++;
          idx++;
        end
        if (c_prog) begin
          if (prog_cyc < 4) stream[prog_cyc] = c_head;
          prog_cyc++;
        end
        last_prog  = c_prog;
        last_ready = c_ready;
        @(posedge CLK); #1;
      end
      c_valid = 1'b0;
      check("c done", 32'(c_done), 32'd1);
      check("c busy_cycles_to_done", 32'(busy_cyc), 32'd8);
      check("c handshakes", 32'(ready_cyc), 32'd4);
      check("c prog_cycles", 32'(prog_cyc), 32'd4);
      check("c no_back_to_back", 32'(back_to_back), 32'd0);
      check("c head_stream", 32'(stream), 32'hD);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Sequences the loading of a configuration-chain (a serial chain of DFF configuration cells driving MUX select bits) from a word-wide stream.
- Accepts CFG_DATA words over a valid/ready handshake and serialises them LSB-first onto the chain head.
- Asserts a shift enable for exactly CHAIN_LEN cycles per programming run, then reports DONE.
- Sits between the bitstream source and the fabric's configuration chain; it is the only driver of chain shifting.

Parameters:
- CHAIN_LEN, 64, number of configuration cells in the chain (>= 1); equals total shift cycles per run.
- WORD_W, 8, width of each incoming configuration word (>= 1).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  single-cycle request to begin a programming run; honoured only in IDLE or DONE.
- CFG_DATA  input  WORD_W  configuration word; bit 0 is shifted first.
- CFG_VALID  input  1  CFG_DATA is valid.
- CFG_READY  output  1  loader accepts a word this cycle.
- CCFF_HEAD  output  1  serial data to chain head.
- PROG_EN  output  1  chain shift enable; the chain samples CCFF_HEAD on each CLK edge where PROG_EN=1.
- BUSY  output  1  a run is in progress (LOAD or SHIFT).
- DONE  output  1  last run completed; held until the next accepted START or RESET.

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE.
- Internal registers:
  - sreg: WORD_W shift register.
  - bit_cnt: counts 0..CHAIN_LEN-1, width $clog2(CHAIN_LEN+1).
  - word_bit: counts 0..WORD_W-1.
- Reset (async, immediate):
  - state=IDLE; sreg, bit_cnt, word_bit = 0.
  - All outputs 0: CFG_READY, CCFF_HEAD, PROG_EN, BUSY, DONE.
- Output decode (all outputs decode from registers only, so no combinational path from inputs to outputs):
  - CFG_READY=1 iff state==LOAD.
  - PROG_EN=1 iff state==SHIFT.
  - CCFF_HEAD = sreg[0] in SHIFT, else 0.
  - BUSY=1 in LOAD or SHIFT.
  - DONE=1 iff state==DONE.
- IDLE: START=1 -> LOAD; clear bit_cnt and word_bit.
- LOAD:
  - CFG_VALID=1 (handshake completes) -> sreg<=CFG_DATA, word_bit<=0, go SHIFT.
  - CFG_VALID=0 -> stay; PROG_EN stays 0, so the chain holds its contents.
- SHIFT, every cycle:
  - sreg<=sreg>>1; bit_cnt++; word_bit++.
  - Exit on the cycle where bit_cnt==CHAIN_LEN-1: go DONE. This check takes priority over the word-end check.
  - Else, exit on the cycle where word_bit==WORD_W-1: go LOAD.
  - Else stay in SHIFT.
- Totals per run:
  - Words consumed = ceil(CHAIN_LEN/WORD_W).
  - Unused high bits of the final word are discarded and never shifted.
  - PROG_EN is high for exactly CHAIN_LEN cycles.
- Chain order: the first bit shifted (bit 0 of word 0) ends at the chain tail cell; the last bit shifted ends at the head cell.
- Latency:
  - START to first CFG_READY: 1 cycle.
  - Handshake to first PROG_EN: 1 cycle.
  - Minimum cost per full word: 1 LOAD cycle + WORD_W SHIFT cycles.
- DONE state:
  - DONE held high; CFG_READY=0.
  - START=1 -> LOAD, clear counters; DONE drops on that edge.
- START in LOAD or SHIFT is ignored; it is not queued.
- CFG_VALID outside LOAD is ignored; the word is not consumed because CFG_READY=0.
- RESET mid-run aborts immediately:
  - PROG_EN drops asynchronously.
  - Chain contents are left partially shifted and undefined for the application.
  - A new START is required.
- Edge cases:
  - CHAIN_LEN a multiple of WORD_W: the last word is fully shifted, then DONE (no extra LOAD).
  - CHAIN_LEN < WORD_W: a single word, partially shifted.
  - WORD_W=1: LOAD and SHIFT alternate, one bit per handshake.

Test Plan:
- CHAIN_LEN=20, WORD_W=8; START, then words 0xA5, 0x3C, 0xF9 with CFG_VALID always high.
  - Required: exactly 3 handshakes, PROG_EN high for 20 cycles in bursts of 8, 8, 4.
  - CCFF_HEAD sequence = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,0,0,1.
  - DONE=1 and BUSY=0 the cycle after the last shift.
  - A 20-bit reference chain model matches.
- Same config; deassert CFG_VALID for 5 cycles before word 2.
  - Required: PROG_EN=0 and CFG_READY=1 for those 5 cycles.
  - Total PROG_EN cycles is still 20; the final chain image is identical to the first scenario.
- CHAIN_LEN=16, WORD_W=8; two words.
  - Required: LOAD entered exactly twice, DONE directly after the 16th shift, no third CFG_READY.
- Pulse START on the 3rd SHIFT cycle, then START again while in DONE.
  - Required: the mid-run START has no effect (bit_cnt continues).
  - The START in DONE clears DONE on the next edge and raises CFG_READY; the second run shifts 20 bits again.
- Assert RESET asynchronously mid-SHIFT (bit_cnt=10).
  - Required: all outputs 0 before the next CLK edge.
  - After release, state is IDLE with no CFG_READY until START; a new run completes normally with 20 PROG_EN cycles.
- WORD_W=1, CHAIN_LEN=4; bits 1,0,1,1.
  - Required: LOAD and SHIFT alternate (8 cycles handshake-to-DONE with VALID always high); CCFF_HEAD = 1,0,1,1.
